// File: rtl/dig_scan_ctrl.sv
// Six-digit multiplexed display scanner: walks digits 1..6 at a CLK_DIV-cycle slot rate,
// with frame-coherent shadow registers, optional leading-zero blanking and a frame_done pulse.
module dig_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] data_in,
  input  logic [5:0]  dp_in,
  input  logic        lzb,
  output logic [2:0]  ctrl,
  output logic [3:0]  code,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned DP_W   = 6;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   data_sh_q, data_sh_d;
  logic [DP_W-1:0]     dp_sh_q, dp_sh_d;
  logic                lzb_sh_q, lzb_sh_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [3:0]          code_q, code_d;
  logic                dp_q, dp_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                load;
  logic [DATA_W-1:0]   upper_data;
  logic [DP_W-1:0]     dp_shift;
  logic                blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd1;
      data_sh_q    <= '0;
      dp_sh_q      <= '0;
      lzb_sh_q     <= 1'b0;
      ctrl_q       <= '0;
      code_q       <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_sh_q    <= data_sh_d;
      dp_sh_q      <= dp_sh_d;
      lzb_sh_q     <= lzb_sh_d;
      ctrl_q       <= ctrl_d;
      code_q       <= code_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_sh_d    = data_sh_q;
    dp_sh_d      = dp_sh_q;
    lzb_sh_d     = lzb_sh_q;
    frame_done_d = 1'b0;
    ctrl_d       = '0;
    code_d       = '0;
    dp_d         = 1'b0;
    load         = 1'b0;
    tick         = (state_q == SCAN) && (cnt_q == CNT_W'(CLK_DIV - 1));

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 3'd1;
        if (en) begin
          state_d = SCAN;
          load    = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 3'd1;
        end else if (tick) begin
          cnt_d = '0;
          if (idx_q == 3'd6) begin
            idx_d        = 3'd1;
            load         = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_sh_d = data_in;
      dp_sh_d   = dp_in;
      lzb_sh_d  = lzb;
    end

    // Outputs are computed from next-state values so they register on the same edge as idx/state.
    upper_data = data_sh_d >> {idx_d - 3'd1, 2'b00};
    dp_shift   = dp_sh_d >> (idx_d - 3'd1);
    blank      = lzb_sh_d && (idx_d != 3'd1) && (upper_data == '0);

    if ((state_d == SCAN) && !blank) begin
      ctrl_d = idx_d;
      code_d = upper_data[3:0];
      dp_d   = dp_shift[0];
    end
  end

  assign ctrl       = ctrl_q;
  assign code       = code_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
